// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive input sweep of a reduction gate with mismatch counting
module gate_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [N_IN-1:0]  first_fail_vec
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3;
  logic [1:0]    state, mode_q;
  logic [CW-1:0] settle_cnt;
  logic          exp_out, mismatch;
  always_comb begin
    exp_out  = mode_q[1] ? (mode_q[0] ? ~|stim : ^stim) : (mode_q[0] ? &stim : |stim);
    mismatch = dut_out != exp_out;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= S_IDLE;
      mode_q         <= '0;
      stim           <= '0;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else case (state)
      S_IDLE, S_DONE: if (start) begin
        mode_q         <= mode;
        stim           <= '0;
        settle_cnt     <= '0;
        err_cnt        <= '0;
        first_fail_vld <= 1'b0;
        first_fail_vec <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        state          <= S_SETTLE;
      end
      S_SETTLE: begin
        settle_cnt <= settle_cnt + CW'(1);
        if (settle_cnt == CW'(SETTLE - 1)) state <= S_SAMPLE;
      end
      default: begin
        if (mismatch) begin
          if (!(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= stim;
          end
        end
        if (&stim) begin
          stim  <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_cnt == '0) && !mismatch;
          state <= S_DONE;
        end else begin
          stim       <= stim + N_IN'(1);
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
      end
    endcase
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: randomized sweeps against a truth-table reference model
module tb_gate_sweep_checker;
  localparam int N = 3, S = 2, LAT = (1 << N) * (S + 1);
  logic clk = 0, rst_n = 1, start = 0, start2 = 0;
  logic [1:0] mode = 0, mode2 = 0;
  logic [N-1:0] stim, stim2, ffvec, ffvec2;
  logic dut_out, dut_out2, busy, busy2, done, done2, pass, pass2, ffv, ffv2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [7:0] tt = 0;
  int kind = 0, kind2 = 5;
  int n_chk = 0, n_fail = 0;

  // kinds 0..3 are the healthy gates in mode order, 4/5 stuck-at, 6 random truth table
  function automatic logic gate_f(int k, logic [N-1:0] v);
    case (k)
      0: return |v;
      1: return &v;
      2: return ^v;
      3: return ~|v;
      4: return 1'b0;
      5: return 1'b1;
      default: return tt[v];
    endcase
  endfunction

  assign dut_out  = gate_f(kind, stim);
  assign dut_out2 = gate_f(kind2, stim2);

  gate_sweep_checker #(.N_IN(N), .SETTLE(S), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vld(ffv), .first_fail_vec(ffvec));

  gate_sweep_checker #(.N_IN(N), .SETTLE(S), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .stim(stim2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_fail_vld(ffv2), .first_fail_vec(ffvec2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic sweep(input logic [1:0] m, input int k, input bit pulse_busy, input string name);
    int errs = 0, ff = 0, lat = -1;
    bit walk_ok = 1;
    for (int v = (1 << N) - 1; v >= 0; v--)
      if (gate_f(k, N'(v)) != gate_f(int'(m), N'(v))) begin
        errs++;
        ff = v;
      end
    kind = k;
    @(negedge clk);
    mode  = m;
    start = 1;
    @(posedge clk);
    for (int j = 0; j < 200 && lat < 0; j++) begin
      @(negedge clk);
      start = 0;
      mode  = 2'($urandom);
      if (pulse_busy && j == 5) begin
        start = 1;
        mode  = ~m;
      end
      if (stim !== N'(j < LAT ? j / (S + 1) : 0) || busy !== (j < LAT) || done !== (j >= LAT))
        walk_ok = 0;
      if (done === 1'b1) lat = j;
    end
    start = 0;
    n_chk++;
    if (!walk_ok || lat != LAT) begin
      n_fail++;
      $display("FAIL %s_walk: latency %0d want %0d, walk_ok %0d", name, lat, LAT, walk_ok);
    end
    n_chk++;
    if (err_cnt !== 8'(errs) || ffv !== (errs > 0) || ffvec !== N'(ff) || pass !== (errs == 0)) begin
      n_fail++;
      $display("FAIL %s_result: err %0d vld %0b vec %0h pass %0b want err %0d vld %0b vec %0h pass %0b",
               name, err_cnt, ffv, ffvec, pass, errs, errs > 0, ff, errs == 0);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1 chk("reset_state", {stim, busy, done, pass, err_cnt, ffv, ffvec}, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_directed;
    sweep(2'b00, 0, 0, "or_pass");
    sweep(2'b00, 4, 0, "stuck0_or");
    sweep(2'b10, 0, 0, "or_as_xor");
    chk("xor_ffvec", ffvec, 3'b011);
    sweep(2'b11, 3, 0, "nor_pass");
  endtask

  task automatic test_saturate;
    int lat = -1;
    kind2 = 5;
    @(negedge clk);
    mode2  = 2'b01;
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    for (int j = 0; j < 100 && lat < 0; j++) begin
      @(negedge clk);
      if (done2 === 1'b1) lat = j;
    end
    chk("sat_done_seen", lat >= 0, 1);
    chk("sat_err_cnt", err_cnt2, 2'b11);
    chk("sat_ffvec", {ffv2, ffvec2}, {1'b1, 3'b000});
    chk("sat_pass", pass2, 0);
  endtask

  task automatic test_midsweep_reset;
    kind = 4;
    @(negedge clk);
    mode  = 2'b00;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("abort_async", {stim, busy, done, pass, err_cnt, ffv, ffvec}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_idle", {busy, done}, 0);
    sweep(2'b00, 0, 0, "restart");
  endtask

  task automatic test_back_to_back;
    sweep(2'b10, 2, 1, "busy_start_ignored");
    sweep(2'b01, 1, 0, "done_restart");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      tt = 8'($urandom);
      sweep(2'($urandom), int'($urandom_range(0, 6)), i[0], "random");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_saturate;
    test_midsweep_reset;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
